led_div_sched: RTL

LED_DIV_SCHED -- requirements
Module: led_div_sched

---
 rtl/led_sched_pkg.sv | 36 +++
 rtl/led_tick_gen.sv | 52 +++++
 rtl/led_div_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED divider scheduler.
// Holds the FSM state encoding, the schedule-table entry layout and the
// small helpers used to step through the table.
package led_sched_pkg;

  localparam int DIV_W   = 5;
  localparam int DWELL_W = 8;
  localparam int IDX_W   = 3;
  localparam int TBL_N   = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DWELL = 3'd3,
    S_MAN   = 3'd4
  } state_t;

  typedef struct packed {
    logic [DIV_W-1:0]   div;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

  // Sequence step: wrap to entry 0 once the last active entry is reached
  // (or when the index already sits beyond a shortened sequence).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] last);
    return (idx >= last) ? '0 : idx + 1'b1;
  endfunction

  // A zero dwell would make an entry vanish; it is stretched to one tick.
  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Dwell timer: a prescaler dividing clk100 by TICK_DIV feeding a tick
// counter that saturates at the terminal count. clr restarts both.
// expire is high in the last cycle of the dwell and stays high while the
// counter is saturated, so an expiry that lands while the scheduler is
// busy elsewhere is still visible when it comes back.
module led_tick_gen
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic               clr,
  input  logic [DWELL_W-1:0] term,
  output logic               expire
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]      presc;
  logic [DWELL_W-1:0] tick_cnt;
  logic               presc_wrap;
  logic               at_term;

  assign presc_wrap = (presc == PRESC_LAST);
  assign at_term    = (tick_cnt == term);

  // Prescaler and tick counter; counting stops once the terminal count is held.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      tick_cnt <= '0;
    end else if (clr) begin
      presc    <= '0;
      tick_cnt <= '0;
    end else if (!at_term) begin
      if (presc_wrap) begin
        presc    <= '0;
        tick_cnt <= tick_cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Expiry: saturated, or the final prescaler cycle of the final tick.
  always_comb begin
    expire = at_term || (presc_wrap && (tick_cnt == (term - DWELL_W'(1))));
  end

endmodule

// File: rtl/led_div_sched.sv
// LED divider scheduler: walks an 8-entry {div, dwell} table, writing each
// divider to the LED counter with a one-cycle wren_o and holding it for
// dwell ticks. A manual request can inject a divider at any IDLE or DWELL
// cycle. Optional one-shot mode (macro LED_SCHED_ONESHOT_EN) stops after the
// last active entry and pulses done_o.
module led_div_sched
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int NUM_ENT  = 8
) (
  input  logic         clk100,
  input  logic         rst,
  input  logic         en_i,
  input  logic [2:0]   len_i,
  input  logic         tbl_we_i,
  input  logic [2:0]   tbl_addr_i,
  input  logic [4:0]   tbl_div_i,
  input  logic [7:0]   tbl_dwell_i,
  input  logic         man_req_i,
  input  logic [4:0]   man_div_i,
  output logic [4:0]   div_o,
  output logic         wren_o,
  output logic         man_ack_o,
  output logic         busy_o,
  output logic [2:0]   idx_o,
`ifdef LED_SCHED_ONESHOT_EN
  output logic         done_o,
`endif
  output logic [2:0]   dbg_state
);

  // Manual handshake: man_req_i is a level held by the requester until it
  // sees man_ack_o. man_ack_o is a single-cycle pulse issued together with
  // the manual wren_o; the requester drops man_req_i in that same cycle.
  // A request raised during LOAD or WRITE waits for the next IDLE/DWELL.

  state_t             state;
  state_t             ret_state;
  entry_t             tbl [NUM_ENT];
  entry_t             cur_ent;
  logic [DWELL_W-1:0] dwell_q;
  logic               tick_clr;
  logic               expire;
  logic               start_ok;

`ifdef LED_SCHED_ONESHOT_EN
  // After a completed one-shot pass, en_i must go low before a restart.
  logic armed;
  assign start_ok = armed;
`else
  assign start_ok = 1'b1;
`endif

  assign cur_ent   = tbl[idx_o];
  assign tick_clr  = (state == S_WRITE);
  assign dbg_state = state;

  // Schedule table; a LOAD in the same cycle as a write sees the old entry.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        tbl[i] <= '0;
      end
    end else if (tbl_we_i) begin
      tbl[tbl_addr_i] <= '{div: tbl_div_i, dwell: tbl_dwell_i};
    end
  end

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk100 (clk100),
    .rst    (rst),
    .clr    (tick_clr),
    .term   (dwell_q),
    .expire (expire)
  );

  // Scheduler FSM with registered outputs; wren_o is high in WRITE and MAN.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      div_o     <= '0;
      wren_o    <= 1'b0;
      man_ack_o <= 1'b0;
      busy_o    <= 1'b0;
      idx_o     <= '0;
      dwell_q   <= '0;
`ifdef LED_SCHED_ONESHOT_EN
      done_o    <= 1'b0;
      armed     <= 1'b1;
`endif
    end else begin
      wren_o    <= 1'b0;
      man_ack_o <= 1'b0;
`ifdef LED_SCHED_ONESHOT_EN
      done_o    <= 1'b0;
      if (!en_i) begin
        armed <= 1'b1;
      end
`endif
      case (state)
        S_IDLE: begin
          if (man_req_i) begin
            state     <= S_MAN;
            ret_state <= S_IDLE;
            div_o     <= man_div_i;
            wren_o    <= 1'b1;
            man_ack_o <= 1'b1;
            busy_o    <= 1'b1;
          end else if (en_i && start_ok) begin
            state  <= S_LOAD;
            idx_o  <= '0;
            busy_o <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!en_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else begin
            div_o   <= cur_ent.div;
            dwell_q <= eff_dwell(cur_ent.dwell);
            wren_o  <= 1'b1;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          state <= S_DWELL;
        end
        S_DWELL: begin
          if (man_req_i) begin
            state     <= S_MAN;
            ret_state <= S_DWELL;
            div_o     <= man_div_i;
            wren_o    <= 1'b1;
            man_ack_o <= 1'b1;
          end else if (!en_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else if (expire) begin
`ifdef LED_SCHED_ONESHOT_EN
            if (idx_o == len_i) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              armed  <= 1'b0;
            end else begin
              idx_o <= next_idx(idx_o, len_i);
              state <= S_LOAD;
            end
`else
            idx_o <= next_idx(idx_o, len_i);
            state <= S_LOAD;
`endif
          end
        end
        S_MAN: begin
          state  <= ret_state;
          busy_o <= (ret_state != S_IDLE);
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
